ccu_cd_router: RTL
==================

// Module: ccu_cd_router
// PURPOSE
// - Routes snoop CD data beats from NoMstPorts cached masters to one of NoUsers CCU consumer units.
// - Consumers are memory unit, snoop unit and future units.
// - Ownership of the CD channel is granted in strict push order through an internal ordering FIFO.
// - Each entry also records which masters will return data; an entry retires once every flagged
//   master has delivered a full line.
// - Sits between the snoop response ports and the ccu_ctrl units.
// - Supersedes the fixed 2-user, 1-bit ordering scheme.
// PARAMETERS
// - NoMstPorts       4    snooped masters (CD channels)
// - NoUsers          2    consumer units; user index width UserW = max(1,$clog2(NoUsers))
// - FifoDepth        4    outstanding ownership entries
// - DcacheLineWidth  128  line bits
// - AxiDataWidth     64   CD beat bits; BeatsPerLine = DcacheLineWidth/AxiDataWidth, must be >= 1
// - snoop_cd_t       logic  CD beat type (carries .data, .last)
// PORTS
// - clk_i          in   1                     clock
// - rst_ni         in   1                     async reset, active low
// - push_valid_i   in   1                     new ownership entry
// - push_ready_o   out  1                     = !full_o
// - push_user_i    in   UserW                 owning consumer
// - push_mask_i    in   NoMstPorts            masters expected to send CD data
// - cd_i           in   NoMstPorts x cd_t     CD beats from masters
// - cd_valid_i     in   NoMstPorts            per-master CD valid
// - cd_ready_o     out  NoMstPorts            per-master CD ready
// - usr_cd_o       out  NoMstPorts x cd_t     = cd_i, broadcast to all users
// - usr_cd_valid_o out  NoUsers x NoMstPorts  routed valid
// - usr_cd_ready_i in   NoUsers x NoMstPorts  consumer ready
// - busy_o         out  NoUsers               user owns the head entry
// - done_o         out  1                     head entry retired this cycle
// - done_user_o    out  UserW                 user of the retired entry
// - full_o         out  1                     FIFO full
// - usage_o        out  $clog2(FifoDepth)+1   occupied entries
// - err_o          out  1                     sticky last-mismatch flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset (asynchronous, any time, including mid-line):
//   - FIFO empty, beat counters 0, err_o 0.
//   - All valid/ready/busy/done outputs 0; done_user_o 0.
//   - An in-flight line is discarded.
// - Push:
//   - Accepted when push_valid_i && push_ready_o.
//   - No fall-through: an entry pushed in cycle t is head no earlier than t+1.
//   - When full, push_ready_o=0 even if the head retires in the same cycle.
//   - Simultaneous push and retire with the FIFO not full: both occur; usage_o is unchanged.
// - Empty FIFO: cd_ready_o=0, usr_cd_valid_o=0, busy_o=0, done_o=0.
// - Head entry {u, mask}:
//   - busy_o[u]=1.
//   - For master m with mask[m]=1 and cnt[m] < BeatsPerLine:
//     - usr_cd_valid_o[u][m] = cd_valid_i[m]
//     - cd_ready_o[m] = usr_cd_ready_i[u][m]
//   - All other masters: ready 0, valid 0. This applies to all other users as well.
// - Beat counter:
//   - cnt[m] increments on each cd_valid_i[m] && cd_ready_o[m] handshake.
//   - Width $clog2(BeatsPerLine+1); a counter never wraps.
// - Retire:
//   - Condition: for every m in mask, cnt[m]==BeatsPerLine, or the final beat handshakes this cycle.
//   - Effect (combinational): done_o=1 and done_user_o=u in the retiring cycle.
//   - Next cycle: pop, all cnt cleared to 0, next entry becomes head.
//   - mask==0 entry: retires in its first head cycle with zero beats.
// - Masters finish independently. A master that has completed its line holds cd_ready_o=0
//   until the head entry changes.
// - usr_cd_o is always a combinational copy of cd_i; there is no added latency on the data path.
// CONFIGURATION
// - Macro CCU_CD_ROUTER_LAST_CHECK_EN.
// - Defined:
//   - On every handshake, compare cd_i[m].last against (cnt[m]==BeatsPerLine-1).
//   - A mismatch sets err_o, which stays set until reset.
//   - Routing behaviour is unaffected.
// - Undefined: err_o tied to 0; .last is ignored; no comparison logic is built.
// STRUCTURE
// - ccu_ctrl_pkg:
//   - Add cd_user_e (MEMORY_UNIT=0, SNOOP_UNIT=1), widened to UserW.
//   - Add localparam function beats_per_line(line_w, data_w).
// - The entry struct {user, mask} is a local typedef because it depends on parameters.
// - Ordering storage uses fifo_v3 (FALL_THROUGH=0, DEPTH=FifoDepth).
// - One sub-module, ccu_cd_beat_counter, generated per master:
//   - Inputs: handshake, clear, mask bit.
//   - Outputs: count, complete, and the optional last-check error.
// TESTING
// - Push {u=1, mask=4'b0101}, BeatsPerLine=2, masters 0 and 2 send 2 beats each with ready=1:
//   4 handshakes, done_o=1 with done_user_o=1 on the last one, usage_o drops 1->0.
// - Push u=0 then u=1, both mask=4'b0001, master 0 streams 4 beats:
//   beats 0-1 go only to usr_cd_valid_o[0][0], beats 2-3 only to [1][0]; done_o pulses twice.
// - Push 4 entries (full_o=1), 5th push held with push_ready_o=0.
//   In the retire cycle push_ready_o is still 0; it becomes 1 the next cycle.
// - Push mask=0 for u=1: done_o on the first head cycle, no cd_ready_o asserted.
// - Master 2 sends both beats while master 0 is stalled (usr_cd_ready_i[0][0]=0):
//   cd_ready_o[2]=0 after its second beat, no retire until master 0 finishes.
// - Assert rst_ni low after 1 of 2 beats: all outputs 0 immediately, usage_o=0.
//   With CCU_CD_ROUTER_LAST_CHECK_EN, last=1 on beat 0 sets err_o.

Source files
------------

// File: rtl/ccu_ctrl_pkg.sv
// Shared CCU control types: consumer unit ids, default CD beat layout and line/beat helper.
package ccu_ctrl_pkg;

  // Consumer unit ids; the router carries them in a UserW-wide field.
  typedef enum logic [0:0] {
    MEMORY_UNIT = 1'b0,
    SNOOP_UNIT  = 1'b1
  } cd_user_e;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_beat_t;

  function automatic int unsigned beats_per_line(input int unsigned line_w,
                                                 input int unsigned data_w);
    return line_w / data_w;
  endfunction

endpackage

// File: rtl/ccu_cd_beat_counter.sv
// Per-master CD beat counter for the head ownership entry.
// CCU_CD_ROUTER_LAST_CHECK_EN adds a .last consistency check on every handshake.
module ccu_cd_beat_counter #(
  parameter int unsigned  BeatsPerLine = 2,
  localparam int unsigned CntW         = $clog2(BeatsPerLine + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            hs_i,
  input  logic            clear_i,
  input  logic            mask_i,
`ifdef CCU_CD_ROUTER_LAST_CHECK_EN
  input  logic            last_i,
  output logic            err_o,
`endif
  output logic [CntW-1:0] cnt_o,
  output logic            complete_o
);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            final_beat;

  assign final_beat = (cnt_q == CntW'(BeatsPerLine - 1));

  // A retire clears the counter even if the final beat lands in that same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hs_i && (cnt_q != CntW'(BeatsPerLine))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign complete_o = !mask_i || (cnt_q == CntW'(BeatsPerLine)) || (hs_i && final_beat);

`ifdef CCU_CD_ROUTER_LAST_CHECK_EN
  assign err_o = hs_i && (last_i != final_beat);
`endif

endmodule

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with optional fall-through; usage_o wraps to 0 when a power-of-2 FIFO is full.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic,
  localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW        = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW-1:0] usage_o,
  input  dtype             data_i,
  input  logic             push_i,
  output dtype             data_o,
  input  logic             pop_i
);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop, bypass;

  assign bypass  = FALL_THROUGH && (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0) && !(bypass && push_i);
  assign usage_o = cnt_q[AddrW-1:0];
  assign do_push = push_i && !full_o && !(bypass && pop_i);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign data_o  = bypass ? data_i : mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == AddrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == AddrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage holds data only, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ccu_cd_router.sv
// Routes snoop CD beats from cached masters to the CCU unit owning the head ordering entry.
// Optional CCU_CD_ROUTER_LAST_CHECK_EN enables the sticky .last mismatch flag on err_o.
module ccu_cd_router import ccu_ctrl_pkg::*; #(
  parameter int unsigned  NoMstPorts      = 4,
  parameter int unsigned  NoUsers         = 2,
  parameter int unsigned  FifoDepth       = 4,
  parameter int unsigned  DcacheLineWidth = 128,
  parameter int unsigned  AxiDataWidth    = 64,
  parameter type          snoop_cd_t      = cd_beat_t,
  localparam int unsigned UserW           = (NoUsers > 1) ? $clog2(NoUsers) : 1,
  localparam int unsigned UsageW          = $clog2(FifoDepth) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [UserW-1:0]                   push_user_i,
  input  logic [NoMstPorts-1:0]              push_mask_i,
  input  snoop_cd_t [NoMstPorts-1:0]         cd_i,
  input  logic [NoMstPorts-1:0]              cd_valid_i,
  output logic [NoMstPorts-1:0]              cd_ready_o,
  output snoop_cd_t [NoMstPorts-1:0]         usr_cd_o,
  output logic [NoUsers-1:0][NoMstPorts-1:0] usr_cd_valid_o,
  input  logic [NoUsers-1:0][NoMstPorts-1:0] usr_cd_ready_i,
  output logic [NoUsers-1:0]                 busy_o,
  output logic                               done_o,
  output logic [UserW-1:0]                   done_user_o,
  output logic                               full_o,
  output logic [UsageW-1:0]                  usage_o,
  output logic                               err_o
);

  localparam int unsigned BeatsPerLine = beats_per_line(DcacheLineWidth, AxiDataWidth);
  localparam int unsigned CntW         = $clog2(BeatsPerLine + 1);
  localparam int unsigned AddrW        = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef struct packed {
    logic [UserW-1:0]      user;
    logic [NoMstPorts-1:0] mask;
  } entry_t;

  entry_t                           push_entry, head;
  logic                             empty, head_vld, retire;
  logic [AddrW-1:0]                 fifo_usage;
  logic [NoMstPorts-1:0]            open, hs, complete;
  logic [NoMstPorts-1:0][CntW-1:0]  cnt;

  assign push_entry   = '{user: push_user_i, mask: push_mask_i};
  assign push_ready_o = !full_o;
  assign head_vld     = !empty;
  assign retire       = head_vld && (&complete);
  assign done_o       = retire;
  assign done_user_o  = retire ? head.user : '0;
  assign usage_o      = UsageW'({full_o, fifo_usage});
  assign usr_cd_o     = cd_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (FifoDepth),
    .dtype        (entry_t)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full_o),
    .empty_o (empty),
    .usage_o (fifo_usage),
    .data_i  (push_entry),
    .push_i  (push_valid_i && push_ready_o),
    .data_o  (head),
    .pop_i   (retire)
  );

  // A master stays open only until its line for the head entry is complete.
  always_comb begin
    open = '0;
    for (int unsigned m = 0; m < NoMstPorts; m++) begin
      open[m] = head_vld && head.mask[m] && (cnt[m] < CntW'(BeatsPerLine));
    end
  end

  always_comb begin
    cd_ready_o     = '0;
    usr_cd_valid_o = '0;
    busy_o         = '0;
    for (int unsigned u = 0; u < NoUsers; u++) begin
      if (head_vld && (head.user == UserW'(u))) begin
        busy_o[u]         = 1'b1;
        usr_cd_valid_o[u] = cd_valid_i & open;
        cd_ready_o        = usr_cd_ready_i[u] & open;
      end
    end
  end

  assign hs = cd_valid_i & cd_ready_o;

`ifdef CCU_CD_ROUTER_LAST_CHECK_EN
  logic [NoMstPorts-1:0] err_vec;
  logic                  err_d, err_q;

  assign err_d = err_q | (|err_vec);
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  assign err_o = 1'b0;
`endif

  for (genvar m = 0; m < NoMstPorts; m++) begin : gen_beat_cnt
    ccu_cd_beat_counter #(
      .BeatsPerLine (BeatsPerLine)
    ) i_beat_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .hs_i       (hs[m]),
      .clear_i    (retire),
      .mask_i     (head.mask[m]),
`ifdef CCU_CD_ROUTER_LAST_CHECK_EN
      .last_i     (cd_i[m].last),
      .err_o      (err_vec[m]),
`endif
      .cnt_o      (cnt[m]),
      .complete_o (complete[m])
    );
  end

endmodule
